// File: rtl/rat_int_ctrl.sv
// Port-mapped interrupt controller for the RAT MCU: MASK/PEND/ACK/ID at BASE_ID+0..3.
// Define RAT_INTC_EDGE_EN for rising-edge capture with W1C acknowledge; default is level capture.
module rat_int_ctrl #(
  parameter int unsigned N_SRC   = 4,
  parameter logic [7:0]  BASE_ID = 8'hF0,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       IN_DATA,
  output logic             IN_SEL,
  output logic             INT_R
);

  localparam int unsigned GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [2:0]       cur_id_q, cur_id_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [7:0] mask_ext, pend_ext, req_ext;
  logic [2:0] win_id;
  logic       wr_mask;
  logic       cur_exit;

  assign wr_mask = IO_STRB && (PORT_ID == BASE_ID);
  assign mask_d  = wr_mask ? OUT_PORT[N_SRC-1:0] : mask_q;

`ifdef RAT_INTC_EDGE_EN
  logic [N_SRC-1:0] irq_prev_q;
  logic             wr_ack;

  assign wr_ack = IO_STRB && (PORT_ID == BASE_ID + 8'd2);
  // A new edge on a bit beats a same-cycle acknowledge of that bit.
  assign pend_d = (pend_q & ~(wr_ack ? OUT_PORT[N_SRC-1:0] : '0)) | (IRQ & ~irq_prev_q);
  assign cur_exit = (wr_ack && OUT_PORT[cur_id_q]) || (wr_mask && !OUT_PORT[cur_id_q]);

  always_ff @(posedge CLK) begin
    if (RESET) irq_prev_q <= '0;
    else       irq_prev_q <= IRQ;
  end
`else
  assign pend_d   = IRQ;
  assign cur_exit = !pend_ext[cur_id_q] || (wr_mask && !OUT_PORT[cur_id_q]);
`endif

  always_comb begin
    mask_ext = '0;
    pend_ext = '0;
    mask_ext[N_SRC-1:0] = mask_q;
    pend_ext[N_SRC-1:0] = pend_q;
    req_ext  = mask_ext & pend_ext;
    win_id   = '0;
    // Scan downwards so the lowest pending index is the last one kept.
    for (int unsigned i = 8; i > 0; i--) begin
      if (req_ext[i-1]) win_id = 3'(i - 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    gap_d    = gap_q;
    case (state_q)
      IDLE: begin
        if (|req_ext) begin
          cur_id_d = win_id;
          state_d  = ASSERT;
        end
      end
      ASSERT: begin
        if (cur_exit) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) state_d = IDLE;
        else                           gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      pend_q   <= '0;
      cur_id_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      cur_id_q <= cur_id_d;
      gap_q    <= gap_d;
    end
  end

  assign INT_R = (state_q == ASSERT);

  always_comb begin
    IN_DATA = '0;
    IN_SEL  = 1'b0;
    if (PORT_ID == BASE_ID) begin
      IN_SEL  = 1'b1;
      IN_DATA = mask_ext;
    end else if (PORT_ID == BASE_ID + 8'd1) begin
      IN_SEL  = 1'b1;
      IN_DATA = pend_ext;
    end else if (PORT_ID == BASE_ID + 8'd3) begin
      IN_SEL  = 1'b1;
      IN_DATA = {(state_q == ASSERT), 4'b0000, cur_id_q};
    end
  end

endmodule
